// File: rtl/cnv_pkg.sv
// ---------------------------------------------------------------------------
// cnv_pkg
// Shared definitions for the convolution frame controller:
//   - cnv_state_e : frame controller FSM states
//   - coord_t     : 12-bit pixel coordinate type used for row/col
//   - CNV_WIDTH_DEF / CNV_HEIGHT_DEF : default frame geometry
//   - coord_is_max() : true when a coordinate sits on the last index of a range
// ---------------------------------------------------------------------------
package cnv_pkg;

    localparam int CNV_WIDTH_DEF  = 320;
    localparam int CNV_HEIGHT_DEF = 320;
    localparam int CNV_COORD_W    = 12;

    typedef logic [CNV_COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } cnv_state_e;

    // True when c is the last valid index of a range of length lim.
    function automatic logic coord_is_max(input coord_t c, input int unsigned lim);
        return (c == coord_t'(lim - 32'd1));
    endfunction

endpackage

// File: rtl/cnv_scan_cnt.sv
// ---------------------------------------------------------------------------
// cnv_scan_cnt
// Raster-order row/column counter for one frame of WIDTH x HEIGHT pixels.
// The counter holds once it reaches the final pixel so the last coordinate
// stays visible to the datapath while the controller drains.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   enable in   advance one pixel (one issue this cycle)
//   clear  in   return to (0,0); has priority over enable
//   row    out  current row    (registered)
//   col    out  current column (registered)
//   last   out  (row,col) is the final pixel of the frame
// ---------------------------------------------------------------------------
module cnv_scan_cnt
    import cnv_pkg::*;
#(
    parameter int WIDTH  = CNV_WIDTH_DEF,
    parameter int HEIGHT = CNV_HEIGHT_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   enable,
    input  logic   clear,
    output coord_t row,
    output coord_t col,
    output logic   last
);

    coord_t r_row;
    coord_t r_col;
    logic   w_col_end;
    logic   w_row_end;

    assign w_col_end = coord_is_max(r_col, WIDTH);
    assign w_row_end = coord_is_max(r_row, HEIGHT);
    assign last      = w_col_end & w_row_end;
    assign row       = r_row;
    assign col       = r_col;

    // Raster position: column wraps into the next row; final pixel holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= 12'd0;
            r_col <= 12'd0;
        end else if (clear) begin
            r_row <= 12'd0;
            r_col <= 12'd0;
        end else if (enable && !last) begin
            if (w_col_end) begin
                r_col <= 12'd0;
                r_row <= r_row + 12'd1;
            end else begin
                r_col <= r_col + 12'd1;
            end
        end else begin
            r_row <= r_row;
            r_col <= r_col;
        end
    end

endmodule

// File: rtl/cnv_ctrl.sv
// ---------------------------------------------------------------------------
// cnv_ctrl
// Frame controller for the convolution datapath. On start it scans every
// pixel of a WIDTH x HEIGHT frame in raster order, issuing one pixel per
// non-stalled cycle, then waits for all issued pixels to return a mac_vld
// before pulsing done.
//
// Optional feature (macro CNV_CTRL_PERF_EN): adds output stall_cyc, a
// saturating count of RUN cycles spent stalled, cleared on accepted start.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   frame start request (accepted only in IDLE)
//   abort     in   frame abort request (forces IDLE, wins over start)
//   stall     in   downstream not ready; scan position holds
//   mac_vld   in   result strobe returned by the datapath
//   row/col   out  pixel coordinate being issued
//   data_run  out  issue strobe (RUN and not stalled)
//   busy      out  high in RUN or DRAIN
//   done      out  one-cycle frame-complete pulse
//   out_cnt   out  mac_vld strobes received in the current frame
//   err       out  sticky protocol error
//   stall_cyc out  stalled RUN cycles (CNV_CTRL_PERF_EN only)
// ---------------------------------------------------------------------------
module cnv_ctrl
    import cnv_pkg::*;
#(
    parameter int WIDTH  = CNV_WIDTH_DEF,
    parameter int HEIGHT = CNV_HEIGHT_DEF,
    parameter int OUT_W  = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             stall,
    input  logic             mac_vld,
    output coord_t           row,
    output coord_t           col,
    output logic             data_run,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] out_cnt,
    output logic             err
`ifdef CNV_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cyc
`endif
);

    cnv_state_e       r_state;
    cnv_state_e       w_state_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [OUT_W-1:0] r_out_cnt;
    logic [OUT_W-1:0] r_outs;
    logic [OUT_W-1:0] w_outs_nxt;

    logic             w_in_run;
    logic             w_issue;
    logic             w_start_acc;
    logic             w_mac_dec;
    logic             w_err_set;
    logic             w_scan_clr;
    logic             w_scan_last;
    coord_t           w_row;
    coord_t           w_col;

    assign w_in_run    = (r_state == ST_RUN);
    // Issue is qualified by the live stall so the datapath sees the pixel
    // in the same cycle the controller commits to it.
    assign w_issue     = w_in_run & ~stall;
    assign w_start_acc = start & ~abort & (r_state == ST_IDLE);
    // A strobe with nothing outstanding is a protocol error, not a decrement.
    assign w_mac_dec   = mac_vld & (r_outs != {OUT_W{1'b0}});
    assign w_err_set   = (mac_vld & (r_outs == {OUT_W{1'b0}}))
                       | (start & (r_state != ST_IDLE));
    assign w_scan_clr  = abort | w_start_acc;

    cnv_scan_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .enable (w_issue),
        .clear  (w_scan_clr),
        .row    (w_row),
        .col    (w_col),
        .last   (w_scan_last)
    );

    // Outstanding-result counter next value: +1 per issue, -1 per result.
    always_comb begin
        w_outs_nxt = r_outs;
        case ({w_issue, w_mac_dec})
            2'b10:   w_outs_nxt = r_outs + OUT_W'(1'b1);
            2'b01:   w_outs_nxt = r_outs - OUT_W'(1'b1);
            default: w_outs_nxt = r_outs;
        endcase
    end

    // FSM next-state; DRAIN looks at the post-update outstanding count so
    // done follows the final result by exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_issue && w_scan_last) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (w_outs_nxt == {OUT_W{1'b0}}) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered status flags decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    // Outstanding results; abort and a new frame both discard in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outs <= {OUT_W{1'b0}};
        end else if (abort || w_start_acc) begin
            r_outs <= {OUT_W{1'b0}};
        end else begin
            r_outs <= w_outs_nxt;
        end
    end

    // Result counter: counts strobes while busy, held across IDLE and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_cnt <= {OUT_W{1'b0}};
        end else if (w_start_acc) begin
            r_out_cnt <= {OUT_W{1'b0}};
        end else if (mac_vld && r_busy) begin
            r_out_cnt <= r_out_cnt + OUT_W'(1'b1);
        end else begin
            r_out_cnt <= r_out_cnt;
        end
    end

    // Sticky error flag, cleared only by reset or an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

`ifdef CNV_CTRL_PERF_EN
    logic [31:0] r_stall_cyc;

    // Saturating count of stalled RUN cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cyc <= 32'd0;
        end else if (w_start_acc) begin
            r_stall_cyc <= 32'd0;
        end else if (w_in_run && stall && (r_stall_cyc != 32'hFFFF_FFFF)) begin
            r_stall_cyc <= r_stall_cyc + 32'd1;
        end else begin
            r_stall_cyc <= r_stall_cyc;
        end
    end

    assign stall_cyc = r_stall_cyc;
`endif

    assign row      = w_row;
    assign col      = w_col;
    assign data_run = w_issue;
    assign busy     = r_busy;
    assign done     = r_done;
    assign out_cnt  = r_out_cnt;
    assign err      = r_err;

endmodule

// File: tb/tb_cnv_ctrl.sv
`timescale 1ns/1ps
module tb_cnv_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort, stall, mac_vld;
    logic [11:0]   row, col;
    logic          data_run, busy, done, err;
    logic [OW-1:0] out_cnt;
`ifdef CNV_CTRL_PERF_EN
    logic [31:0]   stall_cyc;
`endif

    always #5 clk = ~clk;

    cnv_ctrl #(.WIDTH(W), .HEIGHT(H), .OUT_W(OW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .stall    (stall),
        .mac_vld  (mac_vld),
        .row      (row),
        .col      (col),
        .data_run (data_run),
        .busy     (busy),
        .done     (done),
        .out_cnt  (out_cnt),
        .err      (err)
`ifdef CNV_CTRL_PERF_EN
        ,
        .stall_cyc(stall_cyc)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level reference: a frame is "active" while pixels remain to
    // be issued or results remain outstanding; position derives from issue count.
    bit          m_active, m_done, m_err;
    int          m_issued, m_pending, m_outcnt;
    int unsigned m_stallc;

    int echo_q[$];
    int echo_dly = 2;
    int cyc = 0;

    int g_runs, g_dones, g_hold, last_mv_cyc, done_cyc;
    logic g_err_post_start;

    function automatic int exp_row();
        return (m_issued >= N) ? H - 1 : m_issued / W;
    endfunction

    function automatic int exp_col();
        return (m_issued >= N) ? W - 1 : m_issued % W;
    endfunction

    task automatic model_update(input bit s, input bit a, input bit st, input bit r,
                                input bit mv, input bit iss);
        bit idle, sacc, eset;
        int new_pend;
        if (r) begin
            m_active = 0; m_done = 0; m_err = 0;
            m_issued = 0; m_pending = 0; m_outcnt = 0; m_stallc = 0;
        end else begin
            idle = !m_active && !m_done;
            sacc = s && !a && idle;
            eset = (mv && m_pending == 0) || (s && !idle);
            if (sacc) m_outcnt = 0;
            else if (mv && m_active) m_outcnt = (m_outcnt + 1) % (1 << OW);
            if (sacc) m_err = 0;
            else if (eset) m_err = 1;
            if (sacc) m_stallc = 0;
            else if (m_active && m_issued < N && st && m_stallc != 32'hFFFF_FFFF) m_stallc++;
            new_pend = m_pending + (iss ? 1 : 0) - ((mv && m_pending > 0) ? 1 : 0);
            if (a) begin
                m_active = 0; m_done = 0; m_issued = 0; m_pending = 0;
            end else if (sacc) begin
                m_active = 1; m_done = 0; m_issued = 0; m_pending = 0;
            end else begin
                m_done = 0;
                m_pending = new_pend;
                if (m_active) begin
                    if (iss) m_issued++;
                    if (m_issued == N && m_pending == 0) begin
                        m_active = 0;
                        m_done = 1;
                    end
                end
            end
        end
    endtask

    // One clock: drive at negedge, check #1 later, update reference at posedge.
    task automatic step(input bit s, input bit a, input bit st, input bit r, input bit xmv);
        bit mv, iss;
        @(negedge clk);
        mv = xmv;
        for (int i = echo_q.size() - 1; i >= 0; i--) begin
            if (echo_q[i] == cyc) begin
                mv = 1;
                echo_q.delete(i);
            end
        end
        start = s; abort = a; stall = st; rst = r; mac_vld = mv;
        #1;
        iss = m_active && (m_issued < N) && !st;
        chk("data_run", data_run, iss);
        chk("row", row, exp_row());
        chk("col", col, exp_col());
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("out_cnt", out_cnt, m_outcnt);
`ifdef CNV_CTRL_PERF_EN
        chk("stall_cyc", stall_cyc, m_stallc);
`endif
        if (data_run === 1'b1) g_runs++;
        if (done === 1'b1) begin g_dones++; done_cyc = cyc; end
        if (data_run === 1'b0 && busy === 1'b1 && row === 12'd1 && col === 12'd2) g_hold++;
        if (mv) last_mv_cyc = cyc;
        if (iss) echo_q.push_back(cyc + echo_dly);
        @(posedge clk);
        model_update(s, a, st, r, mv, iss);
        cyc++;
    endtask

    task automatic run_frame(input int stall_at, input int stall_len,
                             input int abort_after, input bit rst_drain);
        int sl, guard;
        bit st, ab, rr, abort_pend, aborted, rsted;
        sl = stall_len; guard = 0;
        abort_pend = 0; aborted = 0; rsted = 0;
        g_runs = 0; g_dones = 0; g_hold = 0;
        step(1, 0, 0, 0, 0);
        #1 g_err_post_start = err;
        while ((m_active || m_done) && guard < 200) begin
            st = (sl > 0) && m_active && (m_issued == stall_at);
            if (st) sl--;
            ab = abort_pend;
            abort_pend = 0;
            rr = rst_drain && m_active && (m_issued == N) && !rsted;
            if (rr) begin
                rsted = 1;
                // slow datapath: both remaining results land after the reset
                foreach (echo_q[i]) echo_q[i]++;
            end
            step(0, ab, st, rr, 0);
            if (abort_after > 0 && !aborted && m_issued == abort_after) begin
                abort_pend = 1;
                aborted = 1;
            end
            guard++;
        end
        chk("frame_bound", (guard < 200), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; start = 0; abort = 0; stall = 0; mac_vld = 0;
        m_active = 0; m_done = 0; m_err = 0;
        m_issued = 0; m_pending = 0; m_outcnt = 0; m_stallc = 0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // stray result in IDLE sets err
        step(0, 0, 0, 0, 1);
        #1 chk("r041_err_set", err, 1);

        // plain frame, results echoed two cycles later
        echo_dly = 2;
        run_frame(-1, 0, -1, 0);
        chk("r041_err_clr", g_err_post_start, 0);
        #1;
        chk("r038_issues", g_runs, N);
        chk("r038_dones", g_dones, 1);
        chk("r038_done_lat", done_cyc - last_mv_cyc, 1);
        chk("r038_out_cnt", out_cnt, N);
        chk("r038_err", err, 0);
        chk("r038_busy", busy, 0);
        step(0, 0, 0, 0, 0);

        // three stalled cycles at (1,2)
        run_frame(6, 3, -1, 0);
        #1;
        chk("r039_issues", g_runs, N);
        chk("r039_hold", g_hold, 3);
        chk("r039_dones", g_dones, 1);
        chk("r039_out_cnt", out_cnt, N);
`ifdef CNV_CTRL_PERF_EN
        chk("r039_stall_cyc", stall_cyc, 3);
`endif
        step(0, 0, 0, 0, 0);

        // abort in the cycle after the 5th issue
        run_frame(-1, 0, 5, 0);
        #1;
        chk("r040_busy", busy, 0);
        chk("r040_row", row, 0);
        chk("r040_col", col, 0);
        chk("r040_out_cnt", out_cnt, 4);
        repeat (4) step(0, 0, 0, 0, 0);
        chk("r040_no_done", g_dones, 0);
        chk("r040_out_held", out_cnt, 4);

        // start and abort together in IDLE
        step(1, 1, 0, 0, 0);
        #1 chk("r042_busy", busy, 0);
        step(0, 0, 0, 0, 0);

        // reset during DRAIN with two results outstanding
        run_frame(-1, 0, -1, 1);
        #1;
        chk("r043_busy", busy, 0);
        chk("r043_done", done, 0);
        chk("r043_err", err, 0);
        chk("r043_out_cnt", out_cnt, 0);
        chk("r043_row", row, 0);
        chk("r043_col", col, 0);
        chk("r043_data_run", data_run, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        #1 chk("r043_late_err", err, 1);

        // randomized traffic against the reference
        for (int k = 0; k < 1500; k++) begin
            bit s, a, st, r, x;
            s  = ($urandom_range(0, 15) == 0);
            a  = ($urandom_range(0, 59) == 0);
            st = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 299) == 0);
            x  = ($urandom_range(0, 99) == 0);
            if (s && !m_active && !m_done) echo_dly = $urandom_range(1, 4);
            step(s, a, st, r, x);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
